// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use stall detection; feeds the EX-stage alu.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_alu_ctr,
  input  logic              id_alu_src_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [2:0]        alu_ctr,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_id
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [2:0]        alu_ctr;
    logic              alu_src_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_t;

  ex_t               ex_q, ex_d;
  logic              bubble;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // Newest producer wins; r0 is hardwired so it is never forwarded.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_val
  );
    if (em_we && (em_rd != '0) && (em_rd == idx))      return em_val;
    else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) return mw_val;
    else                                               return reg_val;
  endfunction

  always_comb begin
    stall_id = 1'b0;
    if (!flush && id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)) begin
      if ((ex_q.rd == id_rs) ||
          ((ex_q.rd == id_rt) && (!id_alu_src_imm || id_mem_write)))
        stall_id = 1'b1;
    end
  end

  assign bubble = flush | stall_id;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid       = id_valid;
      ex_d.rs          = id_rs;
      ex_d.rt          = id_rt;
      ex_d.rd          = id_rd;
      ex_d.alu_ctr     = id_alu_ctr;
      ex_d.alu_src_imm = id_alu_src_imm;
      ex_d.reg_write   = id_reg_write;
      ex_d.mem_read    = id_mem_read;
      ex_d.mem_write   = id_mem_write;
      ex_d.rs_data     = id_rs_data;
      ex_d.rt_data     = id_rt_data;
      ex_d.imm         = id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  always_comb begin
    rs_fwd = fwd(ex_q.rs, ex_q.rs_data, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
    rt_fwd = fwd(ex_q.rt, ex_q.rt_data, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
  end

  assign alu_src1      = rs_fwd;
  assign alu_src2      = ex_q.alu_src_imm ? ex_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_ctr       = ex_q.alu_ctr;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: forwarding table, hand-written
// hazard/flush/reset sequences and a randomized run against a reference model.
module tb_id_ex_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [2:0]    id_alu_ctr;
  logic          id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] alu_src1, alu_src2, ex_store_data;
  logic [2:0]    alu_ctr;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;
  logic [AW-1:0] ex_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctr(id_alu_ctr),
    .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall_id(stall_id)
  );

  // Reference model: the instruction the EX stage should currently hold.
  typedef struct {
    bit            valid, simm, rw, mr, mw;
    bit [AW-1:0]   rs, rt, rd;
    bit [2:0]      ctr;
    bit [DW-1:0]   rsd, rtd, imm;
  } ex_m_t;
  ex_m_t m;

  typedef struct {
    bit [AW-1:0] rs, rt;
    bit [DW-1:0] rsd, rtd, imm;
    bit          simm;
    bit          exw;  bit [AW-1:0] exrd;  bit [DW-1:0] exres;
    bit          wbw;  bit [AW-1:0] wbrd;  bit [DW-1:0] wbres;
    bit [DW-1:0] e_src1, e_src2, e_store;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [DW-1:0] ref_fwd(input bit [AW-1:0] idx, input bit [DW-1:0] regv);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
    return regv;
  endfunction

  function automatic bit ref_stall();
    bit uses_rt;
    uses_rt = !id_alu_src_imm || id_mem_write;
    return !flush && id_valid && m.valid && m.mr && m.rd != 0 &&
           (m.rd == id_rs || (m.rd == id_rt && uses_rt));
  endfunction

  task automatic check_model(input string tag);
    bit [DW-1:0] rtf;
    rtf = ref_fwd(m.rt, m.rtd);
    chk({tag, ".src1"},  alu_src1, ref_fwd(m.rs, m.rsd));
    chk({tag, ".src2"},  alu_src2, m.simm ? m.imm : rtf);
    chk({tag, ".store"}, ex_store_data, rtf);
    chk({tag, ".ctr"},   {29'b0, alu_ctr}, {29'b0, m.ctr});
    chk({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, m.valid});
    chk({tag, ".rd"},    {27'b0, ex_rd}, {27'b0, m.rd});
    chk({tag, ".rw"},    {31'b0, ex_reg_write}, {31'b0, m.rw});
    chk({tag, ".mr"},    {31'b0, ex_mem_read}, {31'b0, m.mr});
    chk({tag, ".mw"},    {31'b0, ex_mem_write}, {31'b0, m.mw});
    chk({tag, ".stall"}, {31'b0, stall_id}, {31'b0, ref_stall()});
  endtask

  // Advance one clock; the model captures a bubble on flush or load-use.
  task automatic clk_step();
    ex_m_t nx;
    nx = '{default: 0};
    if (!(flush || ref_stall())) begin
      nx.valid = id_valid; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.ctr = id_alu_ctr; nx.simm = id_alu_src_imm; nx.rw = id_reg_write;
      nx.mr = id_mem_read; nx.mw = id_mem_write;
      nx.rsd = id_rs_data; nx.rtd = id_rt_data; nx.imm = id_imm;
    end
    @(posedge clk);
    m = rst ? '{default: 0} : nx;
    #1;
  endtask

  task automatic set_id(input bit v, input bit [AW-1:0] rs, input bit [AW-1:0] rt,
                        input bit [AW-1:0] rd, input bit [DW-1:0] rsd, input bit [DW-1:0] rtd,
                        input bit [DW-1:0] imm, input bit [2:0] ctr, input bit simm,
                        input bit rw, input bit mr, input bit mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_ctr = ctr; id_alu_src_imm = simm; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic no_writers();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    m = '{default: 0};
    rst = 1; flush = 0; no_writers();
    set_id(1, 1, 2, 3, 32'd2, 32'd2, 0, 3'b010, 0, 1, 0, 0);

    // Reset, then plain add
    #4;
    chk("rst.valid", {31'b0, ex_valid}, 0);
    chk("rst.src1", alu_src1, 0);
    chk("rst.src2", alu_src2, 0);
    chk("rst.ctr", {29'b0, alu_ctr}, 0);
    chk("rst.stall", {31'b0, stall_id}, 0);
    #6 rst = 0;
    clk_step();
    chk("add.src1", alu_src1, 2);
    chk("add.src2", alu_src2, 2);
    chk("add.ctr", {29'b0, alu_ctr}, 3'b010);
    chk("add.valid", {31'b0, ex_valid}, 1);

    // Forwarding vectors
    vecs[0] = '{1, 2, 2, 2, 0, 0, 0,0,0, 0,0,0, 2, 2, 2};
    vecs[1] = '{5, 3, 'hA, 'hB, 0, 0, 1,5,'h11, 1,5,'h22, 'h11, 'hB, 'hB};
    vecs[2] = '{5, 3, 'hA, 'hB, 0, 0, 0,5,'h11, 1,5,'h22, 'h22, 'hB, 'hB};
    vecs[3] = '{5, 3, 'hA, 'hB, 0, 0, 1,0,'h11, 1,0,'h22, 'hA, 'hB, 'hB};
    vecs[4] = '{1, 5, 7, 'hB, 32'hFFFFFFFC, 1, 1,5,'h44, 0,0,0, 7, 32'hFFFFFFFC, 'h44};
    vecs[5] = '{4, 9, 'h1, 'h2, 0, 0, 1,3,'h66, 1,9,'h55, 'h1, 'h55, 'h55};
    vecs[6] = '{0, 9, 'h33, 'h2, 0, 0, 1,0,'h66, 1,0,'h55, 'h33, 'h2, 'h2};
    foreach (vecs[i]) begin
      set_id(1, vecs[i].rs, vecs[i].rt, 6, vecs[i].rsd, vecs[i].rtd, vecs[i].imm,
             3'b010, vecs[i].simm, 1, 0, 0);
      exmem_reg_write = vecs[i].exw; exmem_rd = vecs[i].exrd; exmem_result = vecs[i].exres;
      memwb_reg_write = vecs[i].wbw; memwb_rd = vecs[i].wbrd; memwb_result = vecs[i].wbres;
      clk_step();
      chk($sformatf("vec%0d.src1", i), alu_src1, vecs[i].e_src1);
      chk($sformatf("vec%0d.src2", i), alu_src2, vecs[i].e_src2);
      chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].e_store);
      chk($sformatf("vec%0d.valid", i), {31'b0, ex_valid}, 1);
    end
    no_writers();

    // Load-use stall for one cycle, then the held instruction captures
    set_id(1, 1, 2, 8, 'h10, 'h20, 0, 3'b010, 0, 1, 1, 0);
    clk_step();
    set_id(1, 8, 3, 9, 'h30, 'h40, 0, 3'b010, 0, 1, 0, 0);
    #1 chk("lu.stall", {31'b0, stall_id}, 1);
    clk_step();
    chk("lu.bub_valid", {31'b0, ex_valid}, 0);
    chk("lu.bub_rw", {31'b0, ex_reg_write}, 0);
    chk("lu.stall_gone", {31'b0, stall_id}, 0);
    clk_step();
    chk("lu.held_valid", {31'b0, ex_valid}, 1);
    chk("lu.held_rd", {27'b0, ex_rd}, 9);
    chk("lu.held_src1", alu_src1, 'h30);

    // Load to r0 never stalls
    set_id(1, 1, 2, 0, 'h10, 'h20, 0, 3'b010, 0, 1, 1, 0);
    clk_step();
    set_id(1, 0, 0, 9, 'h30, 'h40, 0, 3'b010, 0, 1, 0, 0);
    #1 chk("lu0.stall", {31'b0, stall_id}, 0);
    clk_step();
    chk("lu0.valid", {31'b0, ex_valid}, 1);

    // rt hazard matters only if rt is read as a register or stored
    set_id(1, 1, 2, 8, 'h10, 'h20, 0, 3'b010, 0, 1, 1, 0);
    clk_step();
    set_id(1, 1, 8, 9, 'h30, 'h40, 4, 3'b010, 1, 1, 0, 0);
    #1 chk("lurt.imm_nostall", {31'b0, stall_id}, 0);
    id_mem_write = 1;
    #1 chk("lurt.store_stall", {31'b0, stall_id}, 1);

    // Flush beats stall
    flush = 1;
    #1 chk("fl.stall", {31'b0, stall_id}, 0);
    clk_step();
    chk("fl.valid", {31'b0, ex_valid}, 0);
    set_id(1, 1, 2, 3, 5, 6, 0, 3'b010, 0, 1, 0, 0);
    clk_step();
    chk("fl2.valid", {31'b0, ex_valid}, 0);
    chk("fl2.ctr", {29'b0, alu_ctr}, 0);
    flush = 0;

    // Async reset mid-cycle
    set_id(1, 1, 2, 3, 'h77, 6, 0, 3'b110, 0, 1, 0, 0);
    clk_step();
    chk("ar.pre_valid", {31'b0, ex_valid}, 1);
    #2 rst = 1;
    #1;
    chk("ar.valid", {31'b0, ex_valid}, 0);
    chk("ar.src1", alu_src1, 0);
    chk("ar.ctr", {29'b0, alu_ctr}, 0);
    m = '{default: 0};
    @(posedge clk); #1;
    chk("ar.held", {31'b0, ex_valid}, 0);
    #2 rst = 0;
    clk_step();
    chk("ar.cap_valid", {31'b0, ex_valid}, 1);
    chk("ar.cap_src1", alu_src1, 'h77);
    chk("ar.cap_ctr", {29'b0, alu_ctr}, 3'b110);

    // Randomized run against the model
    for (int n = 0; n < 300; n++) begin
      set_id($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = $urandom_range(0, 1); exmem_rd = $urandom_range(0, 3);
      exmem_result = $urandom;
      memwb_reg_write = $urandom_range(0, 1); memwb_rd = $urandom_range(0, 3);
      memwb_result = $urandom;
      #1 check_model($sformatf("rnd%0d", n));
      clk_step();
    end
    check_model("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register plus operand-forwarding and load-use hazard logic, sitting directly upstream of the EX-stage alu.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the alu's alu_src1, alu_src2 and alu_ctr inputs.
- Stalls ID when a load result cannot be forwarded in time.

Parameters:
DATA_W, 32, datapath width.
REG_AW, 5, register-address width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
flush  in  1  branch/jump taken; squash the instruction being captured
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register-file read, port rs
id_rt_data  in  DATA_W  register-file read, port rt
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_AW  rs index
id_rt  in  REG_AW  rt index
id_rd  in  REG_AW  destination index (already muxed by RegDst)
id_alu_ctr  in  3  alu operation (000 and, 001 or, 010 add, 110 sub, 111 slt)
id_alu_src_imm  in  1  second operand is the immediate
id_reg_write  in  1  instruction writes a register
id_mem_read  in  1  instruction is a load
id_mem_write  in  1  instruction is a store
exmem_reg_write  in  1  EX/MEM instruction writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM registered alu_result
memwb_reg_write  in  1  MEM/WB instruction writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
alu_src1  out  DATA_W  forwarded rs operand, to alu
alu_src2  out  DATA_W  forwarded rt operand or immediate, to alu
alu_ctr  out  3  registered operation, to alu
ex_valid  out  1  EX stage holds a real instruction
ex_rd  out  REG_AW  EX destination
ex_reg_write  out  1  EX register-write enable
ex_mem_read  out  1  EX load flag
ex_mem_write  out  1  EX store flag
ex_store_data  out  DATA_W  forwarded rt value (store data)
stall_id  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset: asynchronous, active-high; while rst=1 every stage register is 0.
  - Outputs during reset: ex_valid=0, ex_rd=0, all control flags=0, alu_ctr=000, stall_id=0.
  - Outputs derived from zeroed registers: alu_src1=0, ex_store_data=0, alu_src2=0.
- Capture latency: on each rising edge, ID fields are registered into EX. They appear on the outputs in the following cycle.
- Bubble capture: if flush=1 or stall_id=1, a bubble is captured instead of the ID fields.
  - Bubble = ex_valid=0, reg_write=0, mem_read=0, mem_write=0, alu_ctr=000.
  - Data and index fields of a bubble are don't-care; the implementation clears them to 0.
- Forwarding is combinational from the registered EX fields. For each source (rs, then rt):
  - If exmem_reg_write=1, exmem_rd!=0 and exmem_rd equals the source index: use exmem_result.
  - Else if memwb_reg_write=1, memwb_rd!=0 and memwb_rd equals the source index: use memwb_result.
  - Else use the registered register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand outputs:
  - alu_src1 = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_src2 = registered id_imm if the registered alu_src_imm=1; otherwise forwarded rt.
- Load-use hazard: stall_id=1 when all of the following hold:
  - ex_valid=1, ex_mem_read=1, ex_rd!=0;
  - id_valid=1;
  - ex_rd equals id_rs, or ex_rd equals id_rt and (id_alu_src_imm=0 or id_mem_write=1).
  - stall_id is combinational. It lasts exactly one cycle per hazard, because the next EX content is a bubble.
- Simultaneous events:
  - flush=1 forces stall_id=0 and captures a bubble; flush wins over stall.
  - A forwarding match on a bubble has no effect: a bubble's control flags are 0, and a downstream bubble has reg_write=0.
- Reset mid-operation: in-flight EX content is discarded and no partial state survives. The first edge after rst falls captures normally.
- No internal width growth: all operands pass through at DATA_W bits unchanged.

Test Plan:
1. Reset then plain add: rst high 10 ns; capture id_rs_data=2, id_rt_data=2, id_alu_ctr=010, no matching writers -> next cycle alu_src1=2, alu_src2=2, alu_ctr=010, ex_valid=1; all outputs 0 during reset.
2. Double forwarding priority: id_rs=5 with exmem_rd=5, exmem_result=0x11 and memwb_rd=5, memwb_result=0x22 (both reg_write=1) -> alu_src1=0x11. Drop exmem_reg_write -> alu_src1=0x22. Set rd=0 on both -> alu_src1 = registered value.
3. Immediate select: id_alu_src_imm=1, id_imm=0xFFFFFFFC, id_rt=5 matching exmem_rd=5 -> alu_src2=0xFFFFFFFC and ex_store_data=exmem_result.
4. Load-use: EX holds a load with ex_rd=8; ID presents id_rs=8, id_valid=1 -> stall_id=1 for exactly one cycle, next EX is a bubble (ex_valid=0, ex_reg_write=0), then the held instruction captures with stall_id=0. Repeat with ex_rd=0 -> no stall.
5. Flush vs. stall: load-use condition plus flush=1 in the same cycle -> stall_id=0 and a bubble is captured. Assert flush alone on a valid add -> following ex_valid=0, alu_ctr=000.
6. Async reset mid-stream: assert rst between clock edges while ex_valid=1 -> outputs clear immediately, without waiting for a clock edge. Deassert rst -> normal capture on the next edge.
